// File: rtl/rbb_pkg.sv
// Shared definitions for the result batch buffer: FSM states, line geometry
// and the address field helpers used to split a PE word address.
package rbb_pkg;

    localparam int WORDS_PER_LINE = 16;
    localparam int LANE_SEL_W     = 4;

    // One-hot drain FSM states
    typedef enum logic [2:0] {
        ST_COLLECT = 3'b001,
        ST_FETCH   = 3'b010,
        ST_PRESENT = 3'b100
    } rbb_state_t;

    // Line index of a word address (caller trims to the line-index width)
    function automatic logic [31:0] line_field(input logic [31:0] addr);
        return addr >> LANE_SEL_W;
    endfunction

    // Lane select of a word address
    function automatic logic [LANE_SEL_W-1:0] lane_field(input logic [31:0] addr);
        return LANE_SEL_W'(addr);
    endfunction

endpackage

// File: rtl/rbb_lane_ram.sv
// One 32-bit lane of the line buffer: simple dual-port RAM, registered read.
module rbb_lane_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port, one cycle latency
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rbb.sv
// Result batch buffer: collects PE result words into 512-bit lines, then on
// task_done drains lines 0..hwm to the host through a valid/ack handshake.
module rbb
    import rbb_pkg::*;
#(
    parameter int RBB_WR_ADDR_WIDTH = 16,
    parameter int RBB_WR_DATA_WIDTH = 32,
    parameter int RBB_RD_ADDR_WIDTH = 12,
    parameter int RBB_RD_DATA_WIDTH = 512
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         task_done,
    input  logic                         WrEn,
    input  logic [RBB_WR_ADDR_WIDTH-1:0] WrAddr,
    input  logic [RBB_WR_DATA_WIDTH-1:0] WrDin,
    output logic                         Full,
    output logic                         Empty,
    output logic                         WbValid,
    output logic [RBB_RD_ADDR_WIDTH-1:0] WbLineIdx,
    output logic [RBB_RD_DATA_WIDTH-1:0] WbData,
    output logic                         WbLast,
    input  logic                         WbAck,
    output logic                         batch_drained,
    output logic                         Overrun
);

    rbb_state_t                   state_reg, state_next;
    logic [RBB_RD_ADDR_WIDTH-1:0] rd_cnt_reg, rd_cnt_next;
    logic [RBB_RD_ADDR_WIDTH-1:0] hwm_reg, hwm_next;
    logic                         overrun_reg, overrun_next;

    logic [RBB_RD_ADDR_WIDTH-1:0] wr_line;
    logic [LANE_SEL_W-1:0]        wr_lane;
    logic                         wr_accept;
    logic                         at_last;
    logic [RBB_WR_DATA_WIDTH-1:0] lane_rdata [WORDS_PER_LINE];

    assign wr_line   = RBB_RD_ADDR_WIDTH'(line_field(32'(WrAddr)));
    assign wr_lane   = lane_field(32'(WrAddr));
    assign wr_accept = WrEn && (state_reg == ST_COLLECT);
    assign at_last   = (rd_cnt_reg == hwm_reg);

    // Sixteen lane RAMs share the read address; the line counter is held
    // through FETCH and PRESENT so the presented line stays stable.
    generate
        for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_lane
            rbb_lane_ram #(
                .ADDR_W (RBB_RD_ADDR_WIDTH),
                .DATA_W (RBB_WR_DATA_WIDTH)
            ) u_ram (
                .clk     (clk),
                .wr_en   (wr_accept && (wr_lane == LANE_SEL_W'(gi))),
                .wr_addr (wr_line),
                .wr_data (WrDin),
                .rd_addr (rd_cnt_reg),
                .rd_data (lane_rdata[gi])
            );
            assign WbData[RBB_WR_DATA_WIDTH*gi +: RBB_WR_DATA_WIDTH] = lane_rdata[gi];
        end
    endgenerate

    // State, counters and the sticky overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_COLLECT;
            rd_cnt_reg  <= '0;
            hwm_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_cnt_reg  <= rd_cnt_next;
            hwm_reg     <= hwm_next;
            overrun_reg <= overrun_next;
        end
    end

    // Next-state: collect writes, then fetch/present each line until hwm
    always_comb begin
        state_next   = state_reg;
        rd_cnt_next  = rd_cnt_reg;
        hwm_next     = hwm_reg;
        overrun_next = overrun_reg | (WrEn && (state_reg != ST_COLLECT));
        unique case (state_reg)
            ST_COLLECT: begin
                if (WrEn && (wr_line > hwm_reg)) begin
                    hwm_next = wr_line;
                end
                if (task_done) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (WbAck) begin
                    if (at_last) begin
                        rd_cnt_next = '0;
                        hwm_next    = '0;
                        state_next  = ST_COLLECT;
                    end else begin
                        rd_cnt_next = rd_cnt_reg + 1'b1;
                        state_next  = ST_FETCH;
                    end
                end
            end
            default: begin
                state_next = ST_COLLECT;
            end
        endcase
    end

    assign Full          = (state_reg != ST_COLLECT);
    assign Empty         = ~Full;
    assign WbValid       = (state_reg == ST_PRESENT);
    assign WbLineIdx     = rd_cnt_reg;
    assign WbLast        = WbValid && at_last;
    assign batch_drained = WbValid && at_last && WbAck;
    assign Overrun       = overrun_reg;

endmodule
